// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter.
// State codes, port indices and the lock-timeout counter width.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam int PORT_FETCH = 0;
   localparam int PORT_DATA  = 1;

   // idle counter is never narrower than 4 bits
   function automatic int cnt_width(input int lock_max);
      int w;
      w = $clog2(lock_max + 1);
      return (w < 4) ? 4 : w;
   endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant generator producing a one-hot grant.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise port 0 wins.
module arb_rr2
   import mem_arbiter_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic [1:0] mask_i,
   input  logic       update_i,
   output logic [1:0] grant_o
);

   logic [1:0] elig;

   assign elig = valid_i & mask_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // ptr_q = 0 favours port 0, 1 favours port 1
   logic ptr_q;
   logic ptr_d;

   // tie goes to the favoured port, otherwise the lone eligible one
   always_comb begin
      grant_o = elig;
      if (elig == 2'b11) begin
         grant_o = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // after a grant, favour the other port next time
   always_comb begin
      ptr_d = ptr_q;
      if (update_i) begin
         ptr_d = grant_o[PORT_FETCH];
      end
   end

   // pointer register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic unused_w;

   assign unused_w = ^{clk_i, rst_i, update_i};

   // fixed priority: port 0 first
   always_comb begin
      grant_o = 2'b00;
      if (elig[PORT_FETCH]) begin
         grant_o = 2'b01;
      end else if (elig[PORT_DATA]) begin
         grant_o = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch and data ports.
// Optional MEM_ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32,
   parameter int LOCK_MAX  = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req0_valid_i,
   output logic                 req0_ready_o,
   input  logic [ADDR_SIZE-1:0] req0_addr_i,
   input  logic                 req0_wen_i,
   input  logic [WORD_SIZE-1:0] req0_data_i,
   input  logic                 req0_lock_i,
   output logic                 rsp0_valid_o,
   output logic [WORD_SIZE-1:0] rsp0_data_o,
   input  logic                 req1_valid_i,
   output logic                 req1_ready_o,
   input  logic [ADDR_SIZE-1:0] req1_addr_i,
   input  logic                 req1_wen_i,
   input  logic [WORD_SIZE-1:0] req1_data_i,
   input  logic                 req1_lock_i,
   output logic                 rsp1_valid_o,
   output logic [WORD_SIZE-1:0] rsp1_data_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   output logic [WORD_SIZE-1:0] mem_data_o,
   output logic                 mem_wen_o,
   input  logic [WORD_SIZE-1:0] mem_data_i
);

   localparam int CW = cnt_width(LOCK_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

   arb_state_e     state_q;
   logic [CW-1:0]  cnt_q;
   logic [1:0]     mask;
   logic [1:0]     grant;
   logic           xfer;
   logic           sel1;
   logic           lock_sel;
   logic           rsp0_valid_q;
   logic           rsp1_valid_q;
   logic [WORD_SIZE-1:0] rsp0_data_q;
   logic [WORD_SIZE-1:0] rsp1_data_q;

   // eligible ports from ownership; nothing is granted while in reset
   always_comb begin
      mask = 2'b00;
      if (!rst_i) begin
         unique case (state_q)
            IDLE:    mask = 2'b11;
            OWN0:    mask = 2'b01;
            OWN1:    mask = 2'b10;
            default: mask = 2'b00;
         endcase
      end
   end

   arb_rr2 u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  ({req1_valid_i, req0_valid_i}),
      .mask_i   (mask),
      .update_i (xfer),
      .grant_o  (grant)
   );

   assign xfer     = |grant;
   assign sel1     = grant[PORT_DATA];
   assign lock_sel = sel1 ? req1_lock_i : req0_lock_i;

   assign req0_ready_o = grant[PORT_FETCH];
   assign req1_ready_o = grant[PORT_DATA];

   assign mem_addr_o = sel1 ? req1_addr_i : req0_addr_i;
   assign mem_data_o = sel1 ? req1_data_i : req0_data_i;
   assign mem_wen_o  = (grant[PORT_FETCH] & req0_wen_i)
                     | (grant[PORT_DATA]  & req1_wen_i);

   // ownership FSM with idle timeout; a transfer beats the timeout
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else if (xfer) begin
         cnt_q <= '0;
         if (!lock_sel) begin
            state_q <= IDLE;
         end else if (sel1) begin
            state_q <= OWN1;
         end else begin
            state_q <= OWN0;
         end
      end else if (state_q != IDLE) begin
         if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // one-cycle response pulse; data holds between responses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         rsp0_valid_q <= grant[PORT_FETCH];
         rsp1_valid_q <= grant[PORT_DATA];
         if (grant[PORT_FETCH]) begin
            rsp0_data_q <= mem_data_i;
         end
         if (grant[PORT_DATA]) begin
            rsp1_data_q <= mem_data_i;
         end
      end
   end

   assign rsp0_valid_o = rsp0_valid_q;
   assign rsp1_valid_o = rsp1_valid_q;
   assign rsp0_data_o  = rsp0_data_q;
   assign rsp1_data_o  = rsp1_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural memory.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int LM = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_init = 1'b1;
   logic          v0 = 0, v1 = 0;
   logic          w0 = 0, w1 = 0;
   logic          l0 = 0, l1 = 0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic          rdy0, rdy1;
   logic          rv0, rv1;
   logic [DW-1:0] rd0, rd1;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_wen;
   logic [DW-1:0] m_rdata;
   logic [DW-1:0] mem [0:31];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_SIZE (AW),
      .WORD_SIZE (DW),
      .LOCK_MAX  (LM)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_valid_i (v0),
      .req0_ready_o (rdy0),
      .req0_addr_i  (a0),
      .req0_wen_i   (w0),
      .req0_data_i  (d0),
      .req0_lock_i  (l0),
      .rsp0_valid_o (rv0),
      .rsp0_data_o  (rd0),
      .req1_valid_i (v1),
      .req1_ready_o (rdy1),
      .req1_addr_i  (a1),
      .req1_wen_i   (w1),
      .req1_data_i  (d1),
      .req1_lock_i  (l1),
      .rsp1_valid_o (rv1),
      .rsp1_data_o  (rd1),
      .mem_addr_o   (m_addr),
      .mem_data_o   (m_wdata),
      .mem_wen_o    (m_wen),
      .mem_data_i   (m_rdata)
   );

   // memory: async read, sync write, word i = i after init
   assign m_rdata = mem[m_addr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= DW'(i);
      end else if (m_wen) begin
         mem[m_addr] <= m_wdata;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #3;
   endtask

   task automatic test_reset;
      v0 = 1; v1 = 1; w0 = 1; w1 = 1;
      tick();
      tick();
      nvec++; if (rdy0 !== 1'b0) begin nerr++; $display("FAIL rst_rdy0 got %b exp 0", rdy0); end
      nvec++; if (rdy1 !== 1'b0) begin nerr++; $display("FAIL rst_rdy1 got %b exp 0", rdy1); end
      nvec++; if (m_wen !== 1'b0) begin nerr++; $display("FAIL rst_wen got %b exp 0", m_wen); end
      nvec++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin nerr++; $display("FAIL rst_rspv got %b%b exp 00", rv1, rv0); end
      nvec++; if (rd0 !== '0 || rd1 !== '0) begin nerr++; $display("FAIL rst_rspd got %h %h exp 0 0", rd0, rd1); end
      v0 = 0; v1 = 0; w0 = 0; w1 = 0;
      mem_init = 0;
      rst = 0;
      tick();
   endtask

   task automatic test_single_read;
      v0 = 1; a0 = 5; w0 = 0; l0 = 0;
      settle();
      nvec++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin nerr++; $display("FAIL rd_ready got %b%b exp 01", rdy1, rdy0); end
      nvec++; if (m_addr !== 5'd5) begin nerr++; $display("FAIL rd_addr got %0d exp 5", m_addr); end
      tick();
      v0 = 0;
      nvec++; if (rv0 !== 1'b1 || rd0 !== 32'd5) begin nerr++; $display("FAIL rd_rsp got v=%b d=%h exp v=1 d=5", rv0, rd0); end
      nvec++; if (rv1 !== 1'b0) begin nerr++; $display("FAIL rd_rsp1 got %b exp 0", rv1); end
      tick();
      nvec++; if (rv0 !== 1'b0 || rd0 !== 32'd5) begin nerr++; $display("FAIL rd_hold got v=%b d=%h exp v=0 d=5", rv0, rd0); end
   endtask

   task automatic test_write_read;
      v1 = 1; a1 = 3; w1 = 1; d1 = 32'hDEADBEEF; l1 = 0;
      settle();
      nvec++; if (rdy1 !== 1'b1 || m_wen !== 1'b1) begin nerr++; $display("FAIL wr_req got rdy=%b wen=%b exp 1 1", rdy1, m_wen); end
      nvec++; if (m_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL wr_data got %h exp deadbeef", m_wdata); end
      tick();
      w1 = 0;
      nvec++; if (rv1 !== 1'b1 || rd1 !== 32'd3) begin nerr++; $display("FAIL wr_rsp got v=%b d=%h exp v=1 d=3", rv1, rd1); end
      settle();
      nvec++; if (rdy1 !== 1'b1 || m_wen !== 1'b0) begin nerr++; $display("FAIL rd3_req got rdy=%b wen=%b exp 1 0", rdy1, m_wen); end
      tick();
      v1 = 0;
      nvec++; if (rv1 !== 1'b1 || rd1 !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd3_rsp got v=%b d=%h exp v=1 d=deadbeef", rv1, rd1); end
      tick();
   endtask

   task automatic test_tie;
      logic [1:0] exp;
      v0 = 1; a0 = 10; w0 = 0; l0 = 0;
      v1 = 1; a1 = 20; w1 = 0; l1 = 0;
      for (int i = 0; i < 4; i++) begin
         settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp = 2'b01;
`endif
         nvec++;
         if ({rdy1, rdy0} !== exp) begin
            nerr++;
            $display("FAIL tie_c%0d got %b exp %b", i, {rdy1, rdy0}, exp);
         end
         tick();
      end
      v0 = 0; v1 = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      nvec++; if (rv1 !== 1'b1 || rd1 !== 32'd20) begin nerr++; $display("FAIL tie_rsp got v=%b d=%h exp v=1 d=14", rv1, rd1); end
`else
      nvec++; if (rv0 !== 1'b1 || rd0 !== 32'd10) begin nerr++; $display("FAIL tie_rsp got v=%b d=%h exp v=1 d=a", rv0, rd0); end
`endif
      tick();
   endtask

   task automatic test_lock;
      v1 = 1; a1 = 7; w1 = 0; l1 = 1;
      settle();
      nvec++; if (rdy1 !== 1'b1) begin nerr++; $display("FAIL lk_first got %b exp 1", rdy1); end
      tick();
      v0 = 1; a0 = 1; w0 = 0; l0 = 0;
      for (int i = 0; i < 2; i++) begin
         settle();
         nvec++;
         if ({rdy1, rdy0} !== 2'b10) begin
            nerr++;
            $display("FAIL lk_hold%0d got %b exp 10", i, {rdy1, rdy0});
         end
         tick();
      end
      v1 = 0;
      settle();
      nvec++; if (rdy0 !== 1'b0) begin nerr++; $display("FAIL lk_idle got %b exp 0", rdy0); end
      tick();
      v1 = 1; l1 = 0;
      settle();
      nvec++; if ({rdy1, rdy0} !== 2'b10) begin nerr++; $display("FAIL lk_release got %b exp 10", {rdy1, rdy0}); end
      tick();
      v1 = 0;
      settle();
      nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL lk_p0 got %b exp 1", rdy0); end
      tick();
      v0 = 0;
      nvec++; if (rv0 !== 1'b1 || rd0 !== 32'd1) begin nerr++; $display("FAIL lk_rsp got v=%b d=%h exp v=1 d=1", rv0, rd0); end
      tick();
   endtask

   task automatic test_timeout;
      int n;
      v0 = 1; a0 = 2; w0 = 0; l0 = 1;
      settle();
      nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL to_lock got %b exp 1", rdy0); end
      tick();
      v0 = 0;
      v1 = 1; a1 = 4; w1 = 0; l1 = 0;
      n = 0;
      while (n < 40) begin
         settle();
         if (rdy1) break;
         n++;
         tick();
      end
      nvec++; if (n !== LM) begin nerr++; $display("FAIL to_wait got %0d exp %0d", n, LM); end
      tick();
      v1 = 0;
      nvec++; if (rv1 !== 1'b1 || rd1 !== 32'd4) begin nerr++; $display("FAIL to_rsp got v=%b d=%h exp v=1 d=4", rv1, rd1); end
      tick();
   endtask

   task automatic test_timeout_edge;
      int n;
      int g;
      v0 = 1; a0 = 6; w0 = 0; l0 = 1;
      tick();
      v0 = 0;
      v1 = 1; a1 = 8; l1 = 0;
      g = 0;
      for (int i = 0; i < LM - 1; i++) begin
         settle();
         if (rdy1) g++;
         tick();
      end
      nvec++; if (g !== 0) begin nerr++; $display("FAIL te_early got %0d grants exp 0", g); end
      v0 = 1;
      settle();
      nvec++; if ({rdy1, rdy0} !== 2'b01) begin nerr++; $display("FAIL te_edge got %b exp 01", {rdy1, rdy0}); end
      tick();
      v0 = 0;
      n = 0;
      while (n < 40) begin
         settle();
         if (rdy1) break;
         n++;
         tick();
      end
      nvec++; if (n !== LM) begin nerr++; $display("FAIL te_wait got %0d exp %0d", n, LM); end
      tick();
      v1 = 0;
      tick();
   endtask

   task automatic test_reset_mid;
      v1 = 1; a1 = 9; w1 = 1; d1 = 32'h12345678; l1 = 1;
      settle();
      nvec++; if (rdy1 !== 1'b1) begin nerr++; $display("FAIL rm_first got %b exp 1", rdy1); end
      tick();
      d1 = 32'hCAFEF00D;
      #1;
      rst = 1;
      #1;
      nvec++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin nerr++; $display("FAIL rm_ready got %b%b exp 00", rdy1, rdy0); end
      nvec++; if (m_wen !== 1'b0) begin nerr++; $display("FAIL rm_wen got %b exp 0", m_wen); end
      nvec++; if (rv1 !== 1'b0 || rd1 !== '0) begin nerr++; $display("FAIL rm_rsp got v=%b d=%h exp v=0 d=0", rv1, rd1); end
      #1;
      rst = 0;
      v1 = 0; w1 = 0; l1 = 0;
      v0 = 1; a0 = 0; w0 = 0; l0 = 0;
      #1;
      nvec++; if (rdy0 !== 1'b1) begin nerr++; $display("FAIL rm_unlock got %b exp 1", rdy0); end
      v0 = 0;
      v1 = 1;
      #1;
      nvec++; if (rdy1 !== 1'b1) begin nerr++; $display("FAIL rm_p1 got %b exp 1", rdy1); end
      tick();
      v1 = 0;
      nvec++; if (rv1 !== 1'b1 || rd1 !== 32'h12345678) begin nerr++; $display("FAIL rm_rd got v=%b d=%h exp v=1 d=12345678", rv1, rd1); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_read();
      test_tie();
      test_lock();
      test_timeout();
      test_timeout_edge();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port `memory` block (async read, sync write) between an instruction-fetch port (port 0) and a data-access port (port 1). It accepts at most one transaction per cycle and drives the memory port combinationally from the granted request. It returns registered read data one cycle after acceptance and supports a lock so one requester can own the memory for back-to-back accesses (e.g. read-modify-write).

## Interface
- `ADDR_SIZE`, 5, memory address width
- `WORD_SIZE`, 32, data width
- `LOCK_MAX`, 15, idle cycles after which a held lock is forcibly released (≥1)
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; asynchronous, active-high
- `reqN_valid_i`  in  1  request valid, N ∈ {0,1}
- `reqN_ready_o`  out  1  request accepted this cycle (valid & ready = transfer)
- `reqN_addr_i`  in  ADDR_SIZE  address
- `reqN_wen_i`  in  1  1 = write, 0 = read
- `reqN_data_i`  in  WORD_SIZE  write data
- `reqN_lock_i`  in  1  keep grant after this transfer
- `rspN_valid_o`  out  1  one-cycle response pulse
- `rspN_data_o`  out  WORD_SIZE  read data (memory contents before any write)
- `mem_addr_o`  out  ADDR_SIZE  to `memory.addr_i`
- `mem_data_o`  out  WORD_SIZE  to `memory.data_i`
- `mem_wen_o`  out  1  to `memory.wen_i`
- `mem_data_i`  in  WORD_SIZE  from `memory.data_o`

## Operation
- FSM states: IDLE, OWN0, OWN1. Reset → IDLE.
- IDLE: grant goes to the single valid requester. If both are valid, the arbitration policy applies (see Configuration).
- OWNn: only port n may be granted; `req(1-n)_ready_o` = 0.
- Ready is combinational: `reqN_ready_o` = grant to N, and grant requires `reqN_valid_i`. Ready never rises without valid.
- Memory drive:
  - `mem_addr_o` and `mem_data_o` follow the granted port (port 0 when there is no grant).
  - `mem_wen_o` = granted & `wen_i`; it is never asserted without a transfer.
- Transitions on a transfer by port n:
  - `lock_i` = 1 → OWNn.
  - `lock_i` = 0 → IDLE.
- Lock timeout:
  - In OWNn, a 4-bit-minimum idle counter (width ceil(log2(LOCK_MAX+1))) increments each cycle the owner has no transfer.
  - On reaching LOCK_MAX → IDLE; the counter clears.
  - The counter clears on every owner transfer and on entry to OWNn.
- Responses: every transfer (read or write) produces `rspN_valid_o` = 1 in the next cycle, with `rspN_data_o` = `mem_data_i` sampled at the accepting edge. For writes this is the old contents.
- `rspN_data_o` holds its last value while `rspN_valid_o` = 0. There is no response backpressure.

## Timing
- Reset values: all `*_ready_o`, `rsp*_valid_o`, `mem_wen_o` = 0; `rsp*_data_o` = 0; state IDLE; round-robin pointer favours port 0; timeout counter 0.
- Request-to-response latency is 1 cycle. Throughput is 1 transfer per cycle, sustained to a single port.
- Simultaneous valid in IDLE: exactly one ready, per policy. The loser keeps valid asserted and must hold addr/data/wen/lock stable until its ready.
- Timeout edge and owner transfer in the same cycle: the transfer wins and the counter clears.
- Reset mid-operation: pending response is dropped (`rsp*_valid_o` = 0); lock is released.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - IDLE ties go to the port not granted most recently.
  - The pointer updates on every transfer, including locked ones.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: port 0 always wins IDLE ties.
  - No pointer register.

## Structure
- Shared package/include: state encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the port-index constants for fetch (0) and data (1).
- One sub-module, `arb_rr2`: a 2-way grant generator with pointer. Inputs: valid vector, mask (from FSM ownership), update strobe. Output: one-hot grant. Its pointer register is compiled out under fixed priority.
- Top level holds the FSM, timeout counter, memory muxing and response registers.

## Test plan
- Single read: port 0 reads addr 5 from freshly initialised memory (word i = i) → ready 0 in the same cycle; next cycle `rsp0_valid_o` = 1, `rsp0_data_o` = 5.
- Write then read: port 1 writes 0xDEADBEEF to addr 3 (response data = 3), then reads addr 3 → `rsp1_data_o` = 0xDEADBEEF one cycle after the read.
- Tie, both modes:
  - Both ports read continuously for 4 cycles.
  - With RR: grants alternate 0,1,0,1.
  - Without: port 0 is granted 4 times and port 1 is never granted.
- Lock: port 1 transfers with lock = 1 while port 0 is valid → port 0 ready stays 0 until port 1 transfers with lock = 0; port 0 is granted the next cycle.
- Timeout: port 0 locks and then drops valid; port 1 is valid → port 1 is first granted after exactly 15 idle cycles.
- Async reset asserted during a locked transfer → on the same edge all ready/rsp_valid/mem_wen outputs = 0; after release, port 1 is grantable immediately.
